// File: rtl/ram_arbiter_pkg.sv
// Shared types and encodings for the RAM arbiter: FSM states, requester
// indices and the captured access beat.
package ram_arbiter_pkg;
  localparam int DW = 8;

  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_OUT    = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side pins of the arbiter, bundled for port lists.
interface ram_arbiter_if #(parameter int N = 3);
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N-1:0]      lock;
  logic [N-1:0][7:0] addr;
  logic [N-1:0][7:0] wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [7:0]        rdata;
  logic [7:0]        ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  req, we, lock, addr, wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output req, we, lock, addr, wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester after last_i, circularly.
module ram_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          any_o
);
  logic [N-1:0] elig;

  assign elig = req_i & mask_i;

  always_comb begin
    int c;
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    c         = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last_i) + k;
      if (c >= N) c = c - N;
      if (!any_o && elig[c]) begin
        any_o       = 1'b1;
        win_idx_o   = IW'(c);
        win_oh_o[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single-port RAM, with a bounded lock so one
// requester can issue back-to-back beats.
module ram_arbiter #(
  parameter int N        = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);
  import ram_arbiter_pkg::*;

  localparam int IW = idx_w(N);
  localparam int CW = idx_w(MAX_LOCK);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  beat_t         beat_q, beat_d;

  logic [N-1:0]  owner_oh, mask, win_oh, sel_oh;
  logic [IW-1:0] win_idx;
  logic          win_any, own_hold, keep, arb;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign own_hold = bus.lock[owner_q] & bus.req[owner_q];
  assign keep     = own_hold && (int'(cnt_q) < MAX_LOCK - 1);

  // An owner that used up its lock budget steps aside once if anyone else waits.
  assign mask = (state_q == ARB_DATA && own_hold && !keep && |(bus.req & ~owner_oh))
              ? ~owner_oh : {N{1'b1}};

  ram_arbiter_rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req_i     (bus.req),
    .mask_i    (mask),
    .last_i    (last_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    arb     = 1'b0;
    sel_oh  = '0;
    case (state_q)
      ARB_IDLE:  arb = win_any;
      ARB_GRANT: state_d = ARB_DATA;
      ARB_DATA: begin
        if (keep) begin
          state_d = ARB_GRANT;
          cnt_d   = cnt_q + CW'(1);
          sel_oh  = owner_oh;
        end else begin
          cnt_d = '0;
          arb   = win_any;
          if (!win_any) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (arb) begin
      state_d = ARB_GRANT;
      owner_d = win_idx;
      last_d  = win_idx;
      sel_oh  = win_oh;
    end
    // The beat is latched on entry to GRANT so the RAM pins hold afterwards.
    beat_d = beat_q;
    if (|sel_oh) begin
      beat_d = '0;
      for (int i = 0; i < N; i++)
        if (sel_oh[i]) beat_d = '{we: bus.we[i], addr: bus.addr[i], wdata: bus.wdata[i]};
    end
  end

  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    if (state_q == ARB_GRANT) bus.gnt[owner_q] = 1'b1;
    if (state_q == ARB_DATA && !beat_q.we) bus.rvalid[owner_q] = 1'b1;
    bus.ram_we    = (state_q == ARB_GRANT) & beat_q.we;
    bus.ram_addr  = beat_q.addr;
    bus.ram_wdata = beat_q.wdata;
  end

  assign bus.rdata = bus.ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, corner sequences, then a
// randomized run scored against a beat-level round-robin model.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  ram_arbiter_if #(.N(N)) bus ();
  ram_arbiter #(.N(N), .MAX_LOCK(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] seed(input logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : 8'(a * 8'd7 + 8'd3);
  endfunction

  // Synchronous RAM model: unwritten locations read back the seed pattern.
  logic [7:0] mem [256];
  bit [255:0] wr_ok;
  always @(posedge clk) begin
    bus.ram_rdata <= wr_ok[bus.ram_addr] ? mem[bus.ram_addr] : seed(bus.ram_addr);
    if (bus.ram_we) begin
      mem[bus.ram_addr]   <= bus.ram_wdata;
      wr_ok[bus.ram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input int i, input logic w, input logic l,
                       input logic [7:0] a, input logic [7:0] d);
    bus.req[i]   = 1'b1;
    bus.we[i]    = w;
    bus.lock[i]  = l;
    bus.addr[i]  = a;
    bus.wdata[i] = d;
  endtask

  typedef struct {
    int         who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] egnt;
    logic [2:0] erv;
    logic [7:0] erdata;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] rr_exp [3];

  // Reference model state for the randomized run
  logic [N-1:0]      p_req, p_we, p_lock, pend, eg, erv;
  logic [N-1:0][7:0] p_addr, p_wdata;
  logic [7:0]        shadow [256];
  logic [7:0]        rd_val;
  int                own, last, run, rd_own;
  bit                gp, gp2, exp_g, rd_pend, found;

  initial begin
    tbl[0] = '{REQ_CPU,    1'b0, 8'h10, 8'h00, 3'b001, 3'b001, 8'h5A};
    tbl[1] = '{REQ_LOADER, 1'b1, 8'h80, 8'h3C, 3'b010, 3'b000, 8'h00};
    tbl[2] = '{REQ_CPU,    1'b0, 8'h80, 8'h00, 3'b001, 3'b001, 8'h3C};
    tbl[3] = '{REQ_OUT,    1'b0, 8'h10, 8'h00, 3'b100, 3'b100, 8'h5A};
    tbl[4] = '{REQ_OUT,    1'b1, 8'hFF, 8'hC3, 3'b100, 3'b000, 8'h00};
    tbl[5] = '{REQ_LOADER, 1'b0, 8'hFF, 8'h00, 3'b010, 3'b010, 8'hC3};
    tbl[6] = '{REQ_CPU,    1'b1, 8'h00, 8'h01, 3'b001, 3'b000, 8'h00};
    tbl[7] = '{REQ_CPU,    1'b0, 8'h00, 8'h00, 3'b001, 3'b001, 8'h01};
    rr_exp[0] = 8'h5A;
    rr_exp[1] = 8'h3C;
    rr_exp[2] = 8'hC3;

    do_reset();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);

    // Single accesses from idle: gnt at t+1, rvalid/rdata at t+2
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].who, tbl[v].we, 1'b0, tbl[v].addr, tbl[v].wdata);
      @(negedge clk);
      chk("vec_gnt", bus.gnt, tbl[v].egnt);
      chk("vec_ram_we", bus.ram_we, tbl[v].we);
      chk("vec_ram_addr", bus.ram_addr, tbl[v].addr);
      if (tbl[v].we) chk("vec_ram_wdata", bus.ram_wdata, tbl[v].wdata);
      bus.req = '0;
      @(negedge clk);
      chk("vec_gnt_off", bus.gnt, 0);
      chk("vec_data_we", bus.ram_we, 0);
      chk("vec_rvalid", bus.rvalid, tbl[v].erv);
      if (!tbl[v].we) chk("vec_rdata", bus.rdata, tbl[v].erdata);
      @(negedge clk);
    end

    // All three reading continuously: 0,1,2,... every other cycle
    do_reset();
    bus.req = 3'b111;
    bus.addr[0] = 8'h10;
    bus.addr[1] = 8'h80;
    bus.addr[2] = 8'hFF;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 1) begin
        chk("rr_gnt", bus.gnt, 32'd1 << (((cyc - 1) / 2) % 3));
      end else begin
        chk("rr_gap", bus.gnt, 0);
        chk("rr_rvalid", bus.rvalid, 32'd1 << (((cyc - 2) / 2) % 3));
        chk("rr_rdata", bus.rdata, rr_exp[((cyc - 2) / 2) % 3]);
      end
    end
    bus.req = '0;

    // CPU locked with the loader waiting: 4 CPU beats, loader, then CPU again
    do_reset();
    bus.req  = 3'b011;
    bus.lock = 3'b001;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 1) begin
        chk("lock_gnt", bus.gnt, (((cyc - 1) / 2) == 4) ? 32'd2 : 32'd1);
        if (cyc == 9) bus.req[1] = 1'b0;
      end else begin
        chk("lock_gap", bus.gnt, 0);
      end
    end
    bus.req  = '0;
    bus.lock = '0;

    // Reset in the GRANT cycle of a write, then of a read
    do_reset();
    drive(REQ_LOADER, 1'b1, 1'b0, 8'h40, 8'h77);
    @(negedge clk);
    chk("rstw_gnt", bus.gnt, 3'b010);
    chk("rstw_we_pre", bus.ram_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_we", bus.ram_we, 0);
    chk("rstw_gnt_off", bus.gnt, 0);
    bus.req = '0;
    bus.we  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(REQ_CPU, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("rstr_gnt", bus.gnt, 3'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("rstr_gnt_off", bus.gnt, 0);
    chk("rstr_we", bus.ram_we, 0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstr_no_rv0", bus.rvalid, 0);
    @(negedge clk);
    chk("rstr_no_rv1", bus.rvalid, 0);
    bus.req = 3'b111;
    @(negedge clk);
    chk("rstr_first", bus.gnt, 3'b001);
    bus.req = '0;
    @(negedge clk);
    chk("rstr_rv", bus.rvalid, 3'b001);
    chk("rstr_rdata", bus.rdata, 8'h5A);

    // Lock held with req dropped: the waiting loader goes next without delay
    do_reset();
    bus.req  = 3'b011;
    bus.lock = 3'b001;
    @(negedge clk);
    chk("lkdrop_gnt0", bus.gnt, 3'b001);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("lkdrop_gap", bus.gnt, 0);
    @(negedge clk);
    chk("lkdrop_gnt1", bus.gnt, 3'b010);
    bus.req  = '0;
    bus.lock = '0;

    // Randomized traffic against the beat-level model
    do_reset();
    for (int a = 0; a < 256; a++) shadow[a] = seed(8'(a));
    last = N - 1; own = 0; run = 0; rd_own = 0; rd_val = '0;
    gp = 0; gp2 = 0; rd_pend = 0; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        erv = '0;
        if (gp && rd_pend) erv[rd_own] = 1'b1;
        chk("rnd_rvalid", bus.rvalid, erv);
        if (erv != 0) chk("rnd_rdata", bus.rdata, rd_val);
        // A beat is granted whenever the previous cycle was not a grant and
        // somebody was asking; a locked owner keeps it for up to ML beats.
        exp_g = !gp && (p_req != 0);
        eg    = '0;
        if (exp_g) begin
          if (gp2 && p_lock[own] && p_req[own] && run < ML) begin
            run++;
          end else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
              if (!found && p_req[(last + k) % N]) begin
                found = 1;
                own   = (last + k) % N;
              end
            end
            last = own;
            run  = 1;
          end
          eg[own] = 1'b1;
        end
        chk("rnd_gnt", bus.gnt, eg);
        chk("rnd_ram_we", bus.ram_we, exp_g && p_we[own]);
        if (exp_g) begin
          chk("rnd_ram_addr", bus.ram_addr, p_addr[own]);
          if (p_we[own]) begin
            chk("rnd_ram_wdata", bus.ram_wdata, p_wdata[own]);
            shadow[p_addr[own]] = p_wdata[own];
            rd_pend = 0;
          end else begin
            rd_pend = 1;
            rd_val  = shadow[p_addr[own]];
            rd_own  = own;
          end
          pend[own] = 1'b0;
        end
        gp2 = gp;
        gp  = exp_g;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]      = 1'b1;
          bus.we[i]    = 1'($urandom_range(0, 1));
          bus.addr[i]  = 8'h20 + 8'($urandom_range(0, 15));
          bus.wdata[i] = 8'($urandom);
        end
        bus.req[i]  = pend[i];
        bus.lock[i] = ($urandom_range(0, 3) != 0);
      end
      p_req   = bus.req;
      p_we    = bus.we;
      p_lock  = bus.lock;
      p_addr  = bus.addr;
      p_wdata = bus.wdata;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single 8-bit synchronous RAM between up to N requesters: the CPU memory port, the program loader and the output/display fetcher. Requests are arbitrated round-robin; a short bounded lock lets a requester issue back-to-back beats (for example CALL pushing the return address, then the fetch). The block sits between the requester ports and the RAM macro and owns the RAM address, write-enable and write-data pins.

## Interface
- N, 3: number of requesters. Index 0 is CPU, 1 is loader, 2 is output.
- MAX_LOCK, 4: maximum consecutive grants to one locked owner before a forced re-arbitration.
- clk  in  1: clock; everything is on the rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- req  in  N: per-requester access request. Level signal; must stay high until the matching gnt.
- we  in  N: per-requester write (1) or read (0). Held stable with req.
- lock  in  N: per-requester request to keep ownership for the next beat.
- addr  in  N*8: per-requester address. Slice i is [8i+7:8i].
- wdata  in  N*8: per-requester write data, same slicing.
- gnt  out  N: one-hot, one-cycle pulse. The access is presented to the RAM this cycle.
- rvalid  out  N: one-hot, one-cycle pulse for reads only. rdata is valid this cycle.
- rdata  out  8: shared read data; ram_rdata passed through.
- ram_addr  out  8: RAM address.
- ram_we  out  1: RAM write enable.
- ram_wdata  out  8: RAM write data.
- ram_rdata  in  8: RAM read data, one cycle after address.

## Operation
- FSM states: IDLE, GRANT, DATA.
  - IDLE: if any req is high, arbitrate, register the owner and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt[owner]=1. Drive ram_addr/ram_wdata/ram_we from the owner's slice, with ram_we=we[owner]. Always go to DATA.
  - DATA: if the access was a read, rvalid[owner]=1. Then:
    - If lock[owner] and req[owner] are high and lock_cnt<MAX_LOCK-1, keep the owner, increment lock_cnt and go to GRANT.
    - Otherwise, if any req is high, arbitrate, clear lock_cnt and go to GRANT.
    - Otherwise clear lock_cnt and go to IDLE.
- Arbitration: round-robin. Search starts at last_owner+1 mod N and takes the first requester with req high.
  - last_owner updates on every new grant.
  - If MAX_LOCK is reached while the owner still requests, the owner is excluded from that one arbitration when any other req is high. If no other req is high, the owner wins again and lock_cnt restarts at 0.
- lock is ignored when req is low.
- When not in GRANT: ram_we=0, and ram_addr/ram_wdata hold their last values.
- Writes complete at the GRANT edge and produce no rvalid.
- A requester may raise req again in the cycle after gnt. It is then eligible at the next arbitration.
- Dropping req before gnt is a protocol violation. The arbiter samples req only when arbitrating.

## Timing
- Reset values: state=IDLE, last_owner=N-1 (requester 0 wins first), lock_cnt=0, gnt=0, rvalid=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Async reset mid-access drops ram_we immediately. An in-flight read returns no rvalid.
- Latency from idle: req rises in cycle t, gnt in t+1, rvalid/rdata in t+2.
- Throughput: one beat per 2 cycles (GRANT/DATA), whether locked or re-arbitrated. There is no IDLE bubble while requests are pending.
- Worst-case wait for any requester: (N-1)*MAX_LOCK*2 + 2 cycles.
- gnt and rvalid are registered state decodes, so they are glitch-free. rdata is combinational from ram_rdata.

## Structure
- rtl/parameters.v gains ARB_IDLE/ARB_GRANT/ARB_DATA state encodings and REQ_CPU/REQ_LOADER/REQ_OUT indices.
- One sub-module, rr_pick: combinational. Inputs are req, mask and last_owner; outputs are a one-hot winner and its index. It is instantiated once in the FSM.

## Test plan
- Reset, then CPU read of addr 0x10 holding 0x5A: gnt[0] at t+1, rvalid[0] with rdata=0x5A at t+2. ram_we stays 0 throughout.
- All three requesters reading continuously from reset: grants go 0,1,2,0,1,2 on every other cycle, with no IDLE cycles.
- Loader writes 0x3C to 0x80, then CPU reads 0x80: ram_we=1 only in the loader's GRANT cycle; CPU rdata=0x3C; no rvalid for the write.
- CPU holds lock and req while the loader requests, MAX_LOCK=4: exactly 4 consecutive CPU grants, then the loader is granted. With the loader idle, the CPU keeps being granted and lock_cnt restarts.
- rst_n pulled low during GRANT of a read: ram_we=0 and gnt=0 immediately. After release, requester 0 wins first and no stale rvalid appears.
- lock high with req low on the owner: the next arbitration grants the other pending requester without delay.
